dp_arbiter: RTL
===============

DP_ARBITER -- requirements
Module: dp_arbiter

Interface
REQ-001 Parameter LATENCY, default 2, cycles from the dp_en cycle to dp_z valid; legal range 1..15.
REQ-002 Parameter NREQ, default 4, number of requesters; fixed at 4 for this revision.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req  input  4  per-requester request; bit i belongs to requester i.
REQ-006 req_a  input  32  operand a per requester; requester i uses bits [8i+7:8i].
REQ-007 req_b  input  32  operand b per requester; requester i uses bits [8i+7:8i].
REQ-008 ack  output  4  one-hot, one-cycle completion pulse to the granted requester.
REQ-009 result  output  8  captured datapath result; valid while ack is nonzero, held otherwise.
REQ-010 grant_id  output  2  index of the current or last granted requester.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 dp_a  output  8  operand a to the shared datapath.
REQ-013 dp_b  output  8  operand b to the shared datapath.
REQ-014 dp_en  output  1  one-cycle datapath enable.
REQ-015 dp_z  input  8  datapath result, valid LATENCY cycles after the dp_en cycle.

Function
REQ-016 The FSM SHALL have four states: IDLE, ISSUE, WAIT and DONE.
REQ-017 IDLE with req==0 SHALL stay in IDLE.
REQ-018 IDLE with any req bit set SHALL select the first set bit at or after rr_ptr, searching upward with wrap 3->0.
REQ-019 On that selection the block SHALL latch the selected requester's a/b into dp_a/dp_b, load grant_id, and go to ISSUE.
REQ-020 ISSUE SHALL last exactly one cycle with dp_en=1, load a 4-bit counter with LATENCY, and go to WAIT.
REQ-021 WAIT SHALL decrement the counter each cycle.
REQ-022 When the counter is 1, WAIT SHALL capture dp_z into result on that edge and go to DONE; WAIT therefore lasts exactly LATENCY cycles.
REQ-023 DONE SHALL last one cycle and assert ack[grant_id]=1.
REQ-024 DONE SHALL set rr_ptr to (grant_id+1) mod 4 and return to IDLE.
REQ-025 End-to-end latency SHALL be fixed: with req seen in IDLE at cycle 0, dp_en is high in cycle 1 and ack is high in cycle LATENCY+2.
REQ-026 dp_a and dp_b SHALL hold their latched values from ISSUE through DONE, independent of later req_a/req_b changes.
REQ-027 dp_en SHALL be 0 in every state except ISSUE.
REQ-028 Requester protocol: a requester holds req and its operands until it samples ack=1, then clears req on that same edge; the block does not check this.
REQ-029 If req of the granted requester drops after grant, the operation SHALL still complete and ack SHALL still pulse.
REQ-030 req changes outside IDLE SHALL be ignored; arbitration occurs only in IDLE.
REQ-031 With all four req bits held high continuously, grants SHALL rotate 0,1,2,3,0, and no requester waits more than 3 operations.
REQ-032 result SHALL hold its value after DONE until the next capture.
REQ-033 dp_z SHALL be sampled only on the final WAIT edge.

Reset
REQ-034 Reset SHALL force state=IDLE, rr_ptr=0, counter=0, ack=0, dp_en=0, busy=0, dp_a=0, dp_b=0, result=0 and grant_id=0 on the next edge.
REQ-035 Reset asserted in any state, including mid-WAIT, SHALL abort the operation with no ack pulse; reset takes priority over all transitions.

Verification
REQ-036 Bench datapath stub: z = (a+b) mod 256, registered LATENCY deep.
REQ-037 Reset held 6 cycles, then req=0001 with a0=42 and b0=15 -> dp_en high 1 cycle after the req sample, dp_a=42, dp_b=15, ack=0001 with result=57 at cycle LATENCY+2 (cycle 4).
REQ-038 req=1111 held continuously with each requester's operands distinct -> ack sequence 0001, 0010, 0100, 1000, 0001, every result correct, exactly one ack per DONE.
REQ-039 req=1000 after a grant to requester 3, with rr_ptr=0 -> requester 3 is granted again and wrap-around is correct.
REQ-040 Requester 2 granted, req_b changed to 0xFF and req dropped during WAIT -> result uses the original operands and ack=0100 still pulses.
REQ-041 Reset asserted in the second WAIT cycle -> no ack, busy=0 next cycle, and a following req=0100 is granted normally.
REQ-042 Boundary operands a=0xFF, b=0x01 -> result=0x00 (mod 256); repeat the run with LATENCY=1 and LATENCY=15, checking ack timing of 3 and 17 cycles.

Source files
------------

// File: rtl/dp_arbiter_if.sv
// ---------------------------------------------------------------------------
// dp_arbiter_if
// Bundles the requester-side and datapath-side signals of dp_arbiter.
//   req      [3:0]   per-requester request, bit i = requester i
//   req_a    [31:0]  operand a, requester i in bits [8i+7:8i]
//   req_b    [31:0]  operand b, requester i in bits [8i+7:8i]
//   ack      [3:0]   one-hot completion pulse to the granted requester
//   result   [7:0]   captured datapath result, held between captures
//   grant_id [1:0]   index of the current or last granted requester
//   busy             high whenever the arbiter is not idle
//   dp_a/dp_b[7:0]   latched operands presented to the shared datapath
//   dp_en            one-cycle datapath start strobe
//   dp_z     [7:0]   datapath result, valid LATENCY cycles after dp_en
// Modports: slave = the arbiter, master = requesters plus datapath model.
// ---------------------------------------------------------------------------
interface dp_arbiter_if;
    logic [3:0]  req;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [3:0]  ack;
    logic [7:0]  result;
    logic [1:0]  grant_id;
    logic        busy;
    logic [7:0]  dp_a;
    logic [7:0]  dp_b;
    logic        dp_en;
    logic [7:0]  dp_z;

    modport slave (
        input  req, req_a, req_b, dp_z,
        output ack, result, grant_id, busy, dp_a, dp_b, dp_en
    );

    modport master (
        output req, req_a, req_b, dp_z,
        input  ack, result, grant_id, busy, dp_a, dp_b, dp_en
    );
endinterface

// File: rtl/dp_arbiter.sv
// ---------------------------------------------------------------------------
// dp_arbiter
// Round-robin arbiter that shares one fixed-latency 8-bit datapath between
// four requesters. One operation at a time: IDLE picks a requester, ISSUE
// strobes dp_en for one cycle, WAIT counts LATENCY cycles and captures dp_z
// on its last edge, DONE pulses ack to the winner and advances the pointer.
// Ports:
//   clk    single rising-edge clock
//   reset  synchronous, active-high; aborts any operation without ack
//   bus    dp_arbiter_if.slave (requests, operands, ack/result, datapath)
// Parameters:
//   LATENCY  cycles from the dp_en cycle to dp_z valid, 1..15
//   NREQ     number of requesters, fixed at 4
// ---------------------------------------------------------------------------
module dp_arbiter #(
    parameter int LATENCY = 2,
    parameter int NREQ    = 4
) (
    input  logic         clk,
    input  logic         reset,
    dp_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [3:0] LAT_C = 4'(LATENCY);

    state_t      state_r;
    state_t      next_state_s;
    logic [1:0]  rr_ptr_r;
    logic [3:0]  cnt_r;
    logic [3:0]  ack_r;
    logic [7:0]  result_r;
    logic [1:0]  grant_id_r;
    logic        busy_r;
    logic [7:0]  dp_a_r;
    logic [7:0]  dp_b_r;
    logic        dp_en_r;

    logic        pick_valid_s;
    logic [1:0]  pick_idx_s;
    logic        busy_nxt_s;
    logic        dp_en_nxt_s;
    logic [3:0]  ack_nxt_s;

    // First set request bit at or after ptr, searching upward with wrap.
    // Returns {found, index}.
    function automatic logic [2:0] rr_pick(input logic [3:0] req_v,
                                           input logic [1:0] ptr);
        logic       found;
        logic       hit;
        logic [1:0] idx;
        logic [1:0] cand;
        found = 1'b0;
        idx   = 2'd0;
        for (int k = 0; k < NREQ; k++) begin
            // 2-bit addition gives the 3->0 wrap for free
            cand  = ptr + 2'(k);
            hit   = req_v[cand] & ~found;
            idx   = hit ? cand : idx;
            found = found | hit;
        end
        return {found, idx};
    endfunction

    // Round-robin selection, only acted on while idle
    assign {pick_valid_s, pick_idx_s} = rr_pick(bus.req, rr_ptr_r);

    // State register; reset wins over every transition
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (pick_valid_s) begin
                    next_state_s = ST_ISSUE;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                next_state_s = ST_WAIT;
            end
            ST_WAIT: begin
                // count == 1 marks the last WAIT cycle, so WAIT spans LATENCY cycles
                if (cnt_r == 4'd1) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_WAIT;
                end
            end
            ST_DONE: begin
                next_state_s = ST_IDLE;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Output decode from the next state so the flags come straight from flops
    always_comb begin
        busy_nxt_s  = 1'b0;
        dp_en_nxt_s = 1'b0;
        ack_nxt_s   = 4'b0000;
        busy_nxt_s  = (next_state_s != ST_IDLE);
        dp_en_nxt_s = (next_state_s == ST_ISSUE);
        if (next_state_s == ST_DONE) begin
            // grant_id_r is stable from ISSUE onward, so it names the winner here
            ack_nxt_s = 4'b0001 << grant_id_r;
        end else begin
            ack_nxt_s = 4'b0000;
        end
    end

    // Registered control outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_r  <= 1'b0;
            dp_en_r <= 1'b0;
            ack_r   <= 4'b0000;
        end else begin
            busy_r  <= busy_nxt_s;
            dp_en_r <= dp_en_nxt_s;
            ack_r   <= ack_nxt_s;
        end
    end

    // Operand latch, latency counter, result capture and round-robin pointer
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_r   <= 2'd0;
            cnt_r      <= 4'd0;
            result_r   <= 8'd0;
            grant_id_r <= 2'd0;
            dp_a_r     <= 8'd0;
            dp_b_r     <= 8'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    // Operands are frozen here; later req_a/req_b changes are ignored
                    if (pick_valid_s) begin
                        grant_id_r <= pick_idx_s;
                        dp_a_r     <= bus.req_a[{pick_idx_s, 3'b000} +: 8];
                        dp_b_r     <= bus.req_b[{pick_idx_s, 3'b000} +: 8];
                    end
                end
                ST_ISSUE: begin
                    cnt_r <= LAT_C;
                end
                ST_WAIT: begin
                    cnt_r <= cnt_r - 4'd1;
                    // dp_z is trusted only on the final WAIT edge
                    if (cnt_r == 4'd1) begin
                        result_r <= bus.dp_z;
                    end
                end
                ST_DONE: begin
                    rr_ptr_r <= grant_id_r + 2'd1;
                end
                default: begin
                    cnt_r <= 4'd0;
                end
            endcase
        end
    end

    assign bus.ack      = ack_r;
    assign bus.result   = result_r;
    assign bus.grant_id = grant_id_r;
    assign bus.busy     = busy_r;
    assign bus.dp_a     = dp_a_r;
    assign bus.dp_b     = dp_b_r;
    assign bus.dp_en    = dp_en_r;

endmodule
